// File: rtl/rs232tx.sv
// rs232tx: valid/ready byte FIFO feeding an LSB-first UART transmitter (8N1).
// Define RS232TX_PARITY_EN to insert an even-parity bit (8E1).
module rs232tx #(
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned CLOCK_FREQ_HZ = 12000000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TX,
  output logic       busy
);

  localparam int unsigned BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

`ifdef RS232TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
`ifdef RS232TX_PARITY_EN
  logic             r_par;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [OCC_W-1:0] r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic [7:0] w_head;

  assign w_full    = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = valid && !w_full;
  assign w_bit_end = (r_baud == CNT_W'(BIT_PERIOD - 1));
  assign w_head    = r_mem[r_rd];
  // Pop from IDLE, or straight out of a finishing stop bit for gapless frames.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign ready = !w_full;
  assign TX    = r_tx;
  assign busy  = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
    end
  end

  // Frame FSM; r_tx follows the state one cycle later, so every bit keeps its full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef RS232TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_baud <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_baud + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) r_state <= S_START;
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) r_state <= S_DATA;
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
`ifdef RS232TX_PARITY_EN
            if (r_idx == 3'd7) r_state <= S_PARITY;
`else
            if (r_idx == 3'd7) r_state <= S_STOP;
`endif
          end
        end
`ifdef RS232TX_PARITY_EN
        S_PARITY: begin
          r_tx <= r_par;
          if (w_bit_end) r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) r_state <= w_pop ? S_START : S_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
      if (w_pop) begin
        r_shift <= w_head;
        r_idx   <= '0;
`ifdef RS232TX_PARITY_EN
        r_par   <= ^w_head;
`endif
      end
    end
  end

endmodule

// File: doc/rs232tx.md
# rs232tx

Serial UART transmitter for the FTDI link: it accepts bytes from the internal bus through a valid/ready handshake and buffers them in a small FIFO. It emits 8N1 frames (LSB first) on `TX` at `BAUD_RATE`. It is the transmit-side counterpart of the existing UART receiver and uses the same clock and baud parameters, so a TX→RX loopback round-trips bytes unchanged.

## Interface
- `BAUD_RATE`, 9600, serial bit rate in bits/s.
- `CLOCK_FREQ_HZ`, 12000000, frequency of `clk` in Hz.
- `FIFO_DEPTH`, 4, transmit buffer entries; must be a power of 2 and at least 2.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `data`  input  8  byte to send; sampled when `valid && ready`.
- `valid`  input  1  producer has a byte on `data`.
- `ready`  output  1  FIFO can accept a byte (`ready = !full`).
- `TX`  output  1  serial line; idle level is 1.
- `busy`  output  1  high while a frame is in flight or the FIFO is non-empty.

## Operation
- `BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE` (integer division). The default is 1250 cycles.
- Baud counter width is `$clog2(BIT_PERIOD)`. The counter runs 0..`BIT_PERIOD-1`, then wraps.
- FIFO: the write pointer, read pointer and occupancy count are registered.
  - Write occurs on `valid && ready`.
  - `full = (count == FIFO_DEPTH)`; `empty = (count == 0)`.
  - A write and a pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `valid` while `!ready` is ignored: no write, no error, the byte is dropped by the handshake rules and the producer must hold it.
- FSM states: IDLE → START → DATA → STOP → (START | IDLE). With the parity option enabled, DATA → PARITY → STOP.
  - IDLE: `TX=1`. If `!empty`, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: `TX=0` for one `BIT_PERIOD`.
  - DATA: `TX = shift[0]`. Shift right at the end of each `BIT_PERIOD`. After bit index 7, leave DATA.
  - STOP: `TX=1` for one `BIT_PERIOD`.
    - At the end, if `!empty`, pop and go directly to START, so there is no idle gap between back-to-back frames.
    - Otherwise go to IDLE.
- `TX` is driven from a register, so it carries no combinational glitches.
- `busy = (state != IDLE) || !empty`.

## Timing
- Reset values: `TX=1`, `ready=1`, `busy=0`, state IDLE, FIFO empty, counters 0.
- Reset takes effect asynchronously, including mid-frame: `TX` returns to 1 at once, FIFO contents are discarded, and the partial frame is abandoned.
- Latency from accept to line:
  - The byte is accepted on edge k into an empty FIFO while the FSM is IDLE.
  - IDLE sees `!empty` in cycle k+1 and pops on edge k+1.
  - `TX` falls on edge k+2.
- Every bit, start and stop included, is exactly `BIT_PERIOD` cycles. A frame is 10·`BIT_PERIOD` cycles (11 with parity).
- `ready` is combinational from `count`. When full, `ready` goes high in the cycle after a pop.
- `busy` falls on the edge where STOP completes with the FIFO empty.

## Configuration
- `RS232TX_PARITY_EN` defined:
  - PARITY state is inserted after DATA.
  - It drives even parity, `^data`, for one `BIT_PERIOD`.
  - Frame becomes 8E1, 11 bits.
- `RS232TX_PARITY_EN` undefined: no PARITY state, no parity logic, 8N1.

## Test plan
- Single byte: reset, then send 0x55 with defaults.
  - `TX` falls 2 cycles after accept.
  - Line levels are 0,1,0,1,0,1,0,1,0,1, each exactly 1250 cycles.
  - `busy` then drops and `TX` stays 1.
- Back-to-back: push 0x00, 0xFF, 0xA5, 0x3C with `valid` held.
  - Four contiguous frames, 40×1250 cycles total.
  - No idle cycles between the stop bit and the next start bit.
- Overflow: hold `valid` high and offer 6 bytes while the first frame is sending.
  - `ready` goes low after the FIFO holds 4.
  - No byte is lost or duplicated.
  - Bytes appear on `TX` in order.
- Reset mid-frame: assert `rst_n=0` during data bit 3 of 0x0F.
  - `TX=1` immediately, `busy=0`, `ready=1`.
  - After release, nothing is transmitted until a new byte is written.
- Parity (with `RS232TX_PARITY_EN`):
  - Byte 0x07 gives a parity bit of 1; byte 0x03 gives 0.
  - Each frame is 11×1250 cycles.
- Loopback: connect `TX` to the UART receiver's `RX` and send 0x00..0xFF. The receiver reports every value in order with exactly one ready pulse per byte.
